// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// tlc_pkg
// Shared types and constants for the multi-approach traffic-light controller.
//   phase_e  : controller phase (GREEN / YELLOW / ALL_RED), 2-bit encoded
//   LT_*     : per-approach lamp codes, bit order {red, yellow, green}
// ---------------------------------------------------------------------------
package tlc_pkg;

    typedef enum logic [1:0] {
        GREEN   = 2'd0,
        YELLOW  = 2'd1,
        ALL_RED = 2'd2
    } phase_e;

    localparam logic [2:0] LT_GREEN  = 3'b001;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_RED    = 3'b100;

endpackage

// File: rtl/tlc_rr_pick.sv
// ---------------------------------------------------------------------------
// tlc_rr_pick
// Combinational round-robin picker. Finds the first pending approach after
// active_ch, wrapping N_CH-1 to 0. The active approach itself is never picked.
// Ports:
//   pending   in  N_CH   pending-request vector
//   active_ch in  CH_W   approach currently owning the phase
//   next_ch   out CH_W   selected successor (active_ch when none pending)
//   valid     out 1      some approach other than active_ch is pending
// ---------------------------------------------------------------------------
module tlc_rr_pick
    import tlc_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         pending,
    input  logic [$clog2(N_CH)-1:0] active_ch,
    output logic [$clog2(N_CH)-1:0] next_ch,
    output logic                    valid
);

    localparam int CH_W = $clog2(N_CH);

    logic [CH_W-1:0] idx;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        next_ch = active_ch;
        valid   = 1'b0;
        idx     = active_ch;
        // Scan from the farthest successor down to the nearest one, so the
        // nearest pending approach is the last (winning) assignment.
        for (int k = N_CH - 1; k >= 1; k--) begin
            idx = CH_W'((int'(active_ch) + k) % N_CH);
            if (pending[idx]) begin
                next_ch = idx;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlc_multi_phase.sv
// ---------------------------------------------------------------------------
// tlc_multi_phase
// N-approach traffic-light controller. Serves approaches round-robin, skipping
// those without a request, through GREEN -> YELLOW -> ALL_RED phases timed by
// an external one-clock tick pulse. Green holds indefinitely when nobody else
// is waiting.
// Optional feature macro: TLC_EMERGENCY_PREEMPT_EN (adds emg_req / emg_ch).
// Ports:
//   clk        in  1       clock
//   rst        in  1       synchronous active-high reset
//   tick       in  1       timing pulse; timers advance only when high
//   req        in  N_CH    per-approach vehicle sensor (level or pulse)
//   emg_req    in  1       emergency request (feature only)
//   emg_ch     in  CH_W    emergency approach (feature only)
//   light      out 3*N_CH  per approach {red,yellow,green}
//   active_ch  out CH_W    approach currently owning the phase
//   phase      out 2       0=GREEN, 1=YELLOW, 2=ALL_RED
// ---------------------------------------------------------------------------
module tlc_multi_phase
    import tlc_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 6,
    parameter int T_GREEN_MIN = 10,
    parameter int T_GREEN_MAX = 30,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1,
    parameter int HOME_CH     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [N_CH-1:0]         req,
`ifdef TLC_EMERGENCY_PREEMPT_EN
    input  logic                    emg_req,
    input  logic [$clog2(N_CH)-1:0] emg_ch,
`endif
    output logic [3*N_CH-1:0]       light,
    output logic [$clog2(N_CH)-1:0] active_ch,
    output logic [1:0]              phase
);

    localparam int CH_W = $clog2(N_CH);

    if (N_CH < 2 || N_CH > 8 || HOME_CH < 0 || HOME_CH >= N_CH) begin : g_bad_ch
        $error("tlc_multi_phase: N_CH must be 2..8 and HOME_CH < N_CH");
    end
    if (T_GREEN_MIN < 1 || T_GREEN_MAX < T_GREEN_MIN || T_YELLOW < 1 || T_ALLRED < 1 ||
        T_GREEN_MAX >= (1 << CNT_W) || T_YELLOW >= (1 << CNT_W) ||
        T_ALLRED >= (1 << CNT_W)) begin : g_bad_timing
        $error("tlc_multi_phase: phase times out of range for CNT_W");
    end

    // One extra bit so timer+1 compares never wrap.
    localparam logic [CNT_W:0] GMIN = (CNT_W+1)'(T_GREEN_MIN);
    localparam logic [CNT_W:0] GMAX = (CNT_W+1)'(T_GREEN_MAX);
    localparam logic [CNT_W:0] TYEL = (CNT_W+1)'(T_YELLOW);
    localparam logic [CNT_W:0] TAR  = (CNT_W+1)'(T_ALLRED);

    phase_e           state;
    logic [CH_W-1:0]  active_q;
    logic [CH_W-1:0]  next_q;
    logic [CNT_W-1:0] timer;
    logic [N_CH-1:0]  pending;

    logic [CNT_W:0]   timer_inc;
    logic [CH_W-1:0]  rr_next;
    logic [CH_W-1:0]  green_ch;
    logic [N_CH-1:0]  req_set;
    logic [N_CH-1:0]  clear_mask;
    logic             rr_valid;
    logic             min_green_met;
    logic             yellow_done;
    logic             allred_done;

    logic             emg_active;
    logic             emg_hold;
    logic             emg_preempt;
    logic [CH_W-1:0]  emg_sel;

`ifdef TLC_EMERGENCY_PREEMPT_EN
    assign emg_active  = emg_req;
    assign emg_sel     = emg_ch;
    assign emg_hold    = emg_req && (emg_ch == active_q);
    assign emg_preempt = emg_req && (emg_ch != active_q);
`else
    assign emg_active  = 1'b0;
    assign emg_sel     = '0;
    assign emg_hold    = 1'b0;
    assign emg_preempt = 1'b0;
`endif

    tlc_rr_pick #(
        .N_CH (N_CH)
    ) u_rr_pick (
        .pending   (pending),
        .active_ch (active_q),
        .next_ch   (rr_next),
        .valid     (rr_valid)
    );

    assign timer_inc     = {1'b0, timer} + (CNT_W+1)'(1);
    assign min_green_met = tick && (timer_inc >= GMIN) && rr_valid;
    assign yellow_done   = tick && (timer_inc == TYEL);
    assign allred_done   = tick && (timer_inc == TAR);
    // An emergency overrides the latched successor right up to the GREEN edge.
    assign green_ch      = emg_active ? emg_sel : next_q;

    always_comb begin
        req_set = req;
        if (state == GREEN) begin
            req_set[active_q] = 1'b0;
        end
        clear_mask = '0;
        if (state == ALL_RED && allred_done) begin
            clear_mask[green_ch] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= GREEN;
            active_q <= CH_W'(HOME_CH);
            next_q   <= CH_W'(HOME_CH);
            timer    <= '0;
            pending  <= '0;
        end else begin
            // Clear applied after set: an approach entering GREEN drops its
            // request even if its sensor is high on that edge.
            pending <= (pending | req_set) & ~clear_mask;
            unique case (state)
                GREEN: begin
                    if (emg_hold) begin
                        // Emergency on the active approach: hold, timer frozen.
                    end else if (emg_preempt) begin
                        state  <= YELLOW;
                        timer  <= '0;
                        next_q <= emg_sel;
                    end else if (min_green_met) begin
                        state  <= YELLOW;
                        timer  <= '0;
                        next_q <= rr_next;
                    end else if (tick && timer_inc <= GMAX) begin
                        timer <= timer_inc[CNT_W-1:0];
                    end
                end
                YELLOW: begin
                    if (emg_active) next_q <= emg_sel;
                    if (yellow_done) begin
                        state <= ALL_RED;
                        timer <= '0;
                    end else if (tick) begin
                        timer <= timer_inc[CNT_W-1:0];
                    end
                end
                ALL_RED: begin
                    if (emg_active) next_q <= emg_sel;
                    if (allred_done) begin
                        state    <= GREEN;
                        active_q <= green_ch;
                        timer    <= '0;
                    end else if (tick) begin
                        timer <= timer_inc[CNT_W-1:0];
                    end
                end
                default: begin
                    state <= GREEN;
                    timer <= '0;
                end
            endcase
        end
    end

    // Lamp decode straight from registered state: changes on the state edge.
    always_comb begin
        light = {N_CH{LT_RED}};
        for (int i = 0; i < N_CH; i++) begin
            if (CH_W'(i) == active_q) begin
                if (state == GREEN)       light[3*i +: 3] = LT_GREEN;
                else if (state == YELLOW) light[3*i +: 3] = LT_YELLOW;
            end
        end
    end

    assign active_ch = active_q;
    assign phase     = state;

endmodule

// File: tb/tb_tlc_multi_phase.sv
// ---------------------------------------------------------------------------
// tb_tlc_multi_phase
// Scoreboard bench for tlc_multi_phase with default parameters, tick every
// 4th clock. Stimulus pushes each expected phase change (phase, approach,
// tick index) into a queue; a monitor pops and compares whenever the DUT's
// {phase, active_ch} changes, and flags any change nobody expected.
// Define TLC_EMERGENCY_PREEMPT_EN to also exercise the emergency preempt.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tlc_multi_phase;

    logic        clk;
    logic        rst;
    logic        tick;
    logic [3:0]  req;
    logic [11:0] light;
    logic [1:0]  active_ch;
    logic [1:0]  phase;
`ifdef TLC_EMERGENCY_PREEMPT_EN
    logic        emg_req;
    logic [1:0]  emg_ch;
`endif

    tlc_multi_phase dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .req       (req),
`ifdef TLC_EMERGENCY_PREEMPT_EN
        .emg_req   (emg_req),
        .emg_ch    (emg_ch),
`endif
        .light     (light),
        .active_ch (active_ch),
        .phase     (phase)
    );

    typedef struct {
        logic [1:0] ph;
        int         ch;
        int         at_tick;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tick_num = 0;
    int   cyc      = 0;
    logic tick_en  = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick generator: one clock in four.
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc  = cyc + 1;
            tick = tick_en && (cyc % 4 == 0);
        end
    end

    // Counts ticks consumed by the DUT since the last reset edge.
    always @(posedge clk) begin
        if (rst)       tick_num <= 0;
        else if (tick) tick_num <= tick_num + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (tick %0d, t=%0t)", name, act, exp, tick_num, $time);
        end
    endtask

    function automatic logic [11:0] light_of(input logic [1:0] ph, input int ch);
        logic [11:0] l;
        l = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == ch && ph == 2'd0)      l[3*i +: 3] = 3'b001;
            else if (i == ch && ph == 2'd1) l[3*i +: 3] = 3'b010;
            else                            l[3*i +: 3] = 3'b100;
        end
        return l;
    endfunction

    task automatic expect_tr(input logic [1:0] ph, input int ch, input int t);
        exp_t e;
        e.ph = ph;
        e.ch = ch;
        e.at_tick = t;
        exp_q.push_back(e);
    endtask

    task automatic wait_tick(input int n);
        int guard = 0;
        while (tick_num < n && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("wait_tick_reached", 32'(tick_num >= n), 1);
    endtask

    task automatic pulse_req(input int ch);
        req[ch] = 1'b1;
        @(posedge clk);
        #1;
        req[ch] = 1'b0;
    endtask

    task automatic do_reset();
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        check("rst_phase", phase, 0);
        check("rst_active_ch", active_ch, 0);
        check("rst_light", light, 12'b100_100_100_001);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: lamp legality every cycle, scoreboard on each state change.
    initial begin : monitor
        logic [3:0]  prev;
        logic [3:0]  cur;
        logic [2:0]  seg;
        int          nonred;
        int          bad;
        exp_t        e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur    = {phase, active_ch};
            nonred = 0;
            bad    = 0;
            for (int i = 0; i < 4; i++) begin
                seg = light[3*i +: 3];
                if (seg !== 3'b100) nonred++;
                if (seg !== 3'b100 && seg !== 3'b010 && seg !== 3'b001) bad++;
            end
            if (rst !== 1'b1) begin
                check("light_codes_legal", bad, 0);
                check("single_non_red", 32'(nonred <= 1), 1);
                if (cur !== prev) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_transition: phase=%0d active_ch=%0d at tick %0d, required no change",
                                 phase, active_ch, tick_num);
                    end else begin
                        e = exp_q.pop_front();
                        check("trans_phase", phase, e.ph);
                        check("trans_active_ch", active_ch, e.ch);
                        check("trans_tick", tick_num, e.at_tick);
                        check("trans_light", light, light_of(e.ph, e.ch));
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst = 1'b1;
        req = '0;
`ifdef TLC_EMERGENCY_PREEMPT_EN
        emg_req = 1'b0;
        emg_ch  = '0;
`endif
        // Idle: home approach rests green, nothing else ever moves.
        do_reset();
        repeat (200) @(posedge clk);
        #1;
        check("idle_phase", phase, 0);
        check("idle_light", light, 12'b100_100_100_001);

        // Single pulse on approach 2 during min green.
        do_reset();
        wait_tick(2);
        expect_tr(2'd1, 0, 10);
        expect_tr(2'd2, 0, 13);
        expect_tr(2'd0, 2, 14);
        pulse_req(2);
        wait_tick(26);

        // Approaches 1 and 3 queued: served 0->1->3, then back to 0 on re-request.
        do_reset();
        wait_tick(2);
        expect_tr(2'd1, 0, 10);
        expect_tr(2'd2, 0, 13);
        expect_tr(2'd0, 1, 14);
        expect_tr(2'd1, 1, 24);
        expect_tr(2'd2, 1, 27);
        expect_tr(2'd0, 3, 28);
        req[1] = 1'b1;
        req[3] = 1'b1;
        @(posedge clk);
        #1;
        req = '0;
        wait_tick(30);
        expect_tr(2'd1, 3, 38);
        expect_tr(2'd2, 3, 41);
        expect_tr(2'd0, 0, 42);
        pulse_req(0);
        wait_tick(55);

        // Level request after min green: YELLOW on the very next tick.
        do_reset();
        wait_tick(15);
        expect_tr(2'd1, 0, 16);
        expect_tr(2'd2, 0, 19);
        expect_tr(2'd0, 3, 20);
        req[3] = 1'b1;
        wait_tick(22);
        req[3] = 1'b0;
        wait_tick(34);

        // tick held low: timer frozen, nothing moves until ticks resume.
        do_reset();
        wait_tick(2);
        expect_tr(2'd1, 0, 10);
        expect_tr(2'd2, 0, 13);
        expect_tr(2'd0, 1, 14);
        pulse_req(1);
        wait_tick(5);
        tick_en = 1'b0;
        repeat (120) @(posedge clk);
        #1;
        check("frozen_phase", phase, 0);
        check("frozen_tick_count", tick_num, 5);
        tick_en = 1'b1;
        wait_tick(18);

        // Reset in the middle of YELLOW on a non-tick edge; pending is lost.
        do_reset();
        wait_tick(1);
        expect_tr(2'd1, 0, 10);
        pulse_req(1);
        wait_tick(11);
        check("pre_rst_phase", phase, 1);
        do_reset();
        wait_tick(30);
        check("post_rst_phase", phase, 0);

`ifdef TLC_EMERGENCY_PREEMPT_EN
        // Emergency for approach 3 during green of 0: immediate YELLOW, then
        // approach 3 held green while asserted; approach 1 served afterwards.
        do_reset();
        wait_tick(2);
        expect_tr(2'd1, 0, 2);
        expect_tr(2'd2, 0, 5);
        expect_tr(2'd0, 3, 6);
        emg_ch  = 2'd3;
        emg_req = 1'b1;
        wait_tick(8);
        pulse_req(1);
        wait_tick(40);
        check("emg_hold_phase", phase, 0);
        check("emg_hold_ch", active_ch, 3);
        expect_tr(2'd1, 3, 50);
        expect_tr(2'd2, 3, 53);
        expect_tr(2'd0, 1, 54);
        emg_req = 1'b0;
        wait_tick(58);
`endif

        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
